// File: rtl/car_lane_ctrl.sv
// Per-lane car motion controller: advances the car sprite origin once per
// N frame ticks with wrap-around and latches a collision against the player.
module car_lane_ctrl #(
  parameter int H_RES    = 640,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int SPD_W    = 4,
  parameter int DIV_W    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_tick,
  input  logic             en,
  input  logic             dir,
  input  logic [SPD_W-1:0] speed,
  input  logic [DIV_W-1:0] frame_div,
  input  logic             load,
  input  logic [10:0]      x_init,
  input  logic [10:0]      y_lane,
  input  logic [10:0]      px,
  input  logic [10:0]      py,
  input  logic             clr_hit,
  output logic [10:0]      x0,
  output logic [10:0]      y0,
  output logic             hit,
  output logic             moving
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [11:0] HRES12 = 12'(H_RES);
  localparam logic [11:0] SW12   = 12'(SPRITE_W);
  localparam logic [11:0] SH12   = 12'(SPRITE_H);

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt, div_nx;
  logic [10:0]      x_nx, y_nx;
  logic             hit_nx;
  logic [11:0]      dx, dy, adx, ady;
  logic             overlap;
  logic             step_due;

  // One move step in 12-bit arithmetic; result always lies in [0, H_RES-1].
  function automatic logic [10:0] move_x(input logic [10:0] x,
                                         input logic [SPD_W-1:0] spd,
                                         input logic left);
    logic [11:0] x12;
    logic [11:0] sp12;
    logic [11:0] s12;
    x12  = {1'b0, x};
    sp12 = 12'(spd);
    if (left) begin
      if (x12 < sp12) s12 = x12 + HRES12 - sp12;
      else            s12 = x12 - sp12;
    end else begin
      s12 = x12 + sp12;
      if (s12 >= HRES12) s12 = s12 - HRES12;
      else               s12 = s12;
    end
    return s12[10:0];
  endfunction

  // Bounding-box overlap on the current registered origins (no wrap awareness).
  always_comb begin
    dx      = {1'b0, x0} - {1'b0, px};
    dy      = {1'b0, y0} - {1'b0, py};
    adx     = dx[11] ? (12'd0 - dx) : dx;
    ady     = dy[11] ? (12'd0 - dy) : dy;
    overlap = (adx < SW12) && (ady < SH12);
  end

  // Next-state, divider, position and hit-latch logic; load overrides all.
  always_comb begin
    state_nx = state;
    div_nx   = div_cnt;
    x_nx     = x0;
    y_nx     = y0;
    hit_nx   = hit;
    step_due = (div_cnt == frame_div);
    if (load) begin
      x_nx     = x_init;
      y_nx     = y_lane;
      div_nx   = '0;
      hit_nx   = 1'b0;
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (en) state_nx = RUN;
          else    state_nx = IDLE;
        end
        RUN: begin
          if (!en) begin
            state_nx = IDLE;
          end else if (frame_tick) begin
            // Divider keeps counting on a collision tick; only the move is dropped.
            if (step_due) div_nx = '0;
            else          div_nx = div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
            if (overlap) begin
              hit_nx   = 1'b1;
              state_nx = HALT;
            end else if (step_due) begin
              x_nx = move_x(x0, speed, dir);
            end else begin
              x_nx = x0;
            end
          end else begin
            state_nx = RUN;
          end
        end
        HALT: begin
          if (clr_hit) begin
            hit_nx   = 1'b0;
            state_nx = en ? RUN : IDLE;
          end else begin
            state_nx = HALT;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      div_cnt <= '0;
      x0      <= 11'd0;
      y0      <= 11'd0;
      hit     <= 1'b0;
      moving  <= 1'b0;
    end else begin
      state   <= state_nx;
      div_cnt <= div_nx;
      x0      <= x_nx;
      y0      <= y_nx;
      hit     <= hit_nx;
      moving  <= (state_nx == RUN);
    end
  end

endmodule

// File: tb/tb_car_lane_ctrl.sv
// Self-checking bench for car_lane_ctrl: directed plan steps followed by
// randomized traffic, all checked against a behavioural lane model.
module tb_car_lane_ctrl;

  localparam int HR = 640;

  logic        clk = 1'b0;
  logic        reset, frame_tick, en, dir, load, clr_hit;
  logic [3:0]  speed, frame_div;
  logic [10:0] x_init, y_lane, px, py;
  logic [10:0] x0, y0;
  logic        hit, moving;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: mode 0 idle, 1 running, 2 halted on a hit.
  int m_x, m_y, m_hit, m_cnt, m_mode;

  car_lane_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .en(en), .dir(dir),
    .speed(speed), .frame_div(frame_div), .load(load), .x_init(x_init),
    .y_lane(y_lane), .px(px), .py(py), .clr_hit(clr_hit),
    .x0(x0), .y0(y0), .hit(hit), .moving(moving)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Apply the lane rules to the model for the edge about to happen.
  task automatic model_edge();
    bit olap, fire;
    if (reset) begin
      m_x = 0; m_y = 0; m_hit = 0; m_cnt = 0; m_mode = 0;
    end else if (load) begin
      m_x = x_init; m_y = y_lane; m_hit = 0; m_cnt = 0; m_mode = 0;
    end else if (m_mode == 0) begin
      if (en) m_mode = 1;
    end else if (m_mode == 1) begin
      if (!en) m_mode = 0;
      else if (frame_tick) begin
        olap  = (iabs(m_x - int'(px)) < 32) && (iabs(m_y - int'(py)) < 32);
        fire  = (m_cnt == int'(frame_div));
        m_cnt = fire ? 0 : (m_cnt + 1) % 16;
        if (olap) begin
          m_hit = 1; m_mode = 2;
        end else if (fire) begin
          if (dir) m_x = (m_x - int'(speed) + HR) % HR;
          else     m_x = (m_x + int'(speed)) % HR;
        end
      end
    end else if (clr_hit) begin
      m_hit = 0; m_mode = en ? 1 : 0;
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("x0", 32'(x0), 32'(m_x));
    check("y0", 32'(y0), 32'(m_y));
    check("hit", 32'(hit), 32'(m_hit));
    check("moving", 32'(moving), (m_mode == 1) ? 32'd1 : 32'd0);
  endtask

  task automatic do_load(input int xi, input int yl);
    load = 1'b1; x_init = 11'(xi); y_lane = 11'(yl);
    step();
    load = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 1'b0; en = 1'b0; dir = 1'b0; load = 1'b0;
    clr_hit = 1'b0; speed = 4'd0; frame_div = 4'd0;
    x_init = 11'd0; y_lane = 11'd0; px = 11'd1500; py = 11'd1500;
    m_x = 0; m_y = 0; m_hit = 0; m_cnt = 0; m_mode = 0;
    step();
    step();
    check("reset_x0", 32'(x0), 32'd0);
    check("reset_moving", 32'(moving), 32'd0);
    reset = 1'b0;

    // 1: basic right motion, one move per tick
    en = 1'b1; dir = 1'b0; speed = 4'd4; frame_div = 4'd0;
    do_load(100, 200);
    check("load_idle", 32'(moving), 32'd0);
    step();
    check("run_moving", 32'(moving), 32'd1);
    tick(); check("t1_x0", 32'(x0), 32'd104);
    tick(); check("t1_x1", 32'(x0), 32'd108);
    tick(); check("t1_x2", 32'(x0), 32'd112);
    check("t1_y0", 32'(y0), 32'd200);

    // 2: divide by three
    frame_div = 4'd2; speed = 4'd8;
    do_load(0, 200);
    step();
    for (int i = 0; i < 6; i++) begin
      tick();
      step();
      if (i == 1) check("t2_hold", 32'(x0), 32'd0);
      if (i == 2) check("t2_x8", 32'(x0), 32'd8);
      if (i == 5) check("t2_x16", 32'(x0), 32'd16);
    end

    // 3: wrap right then left
    frame_div = 4'd0; speed = 4'd6; dir = 1'b0;
    do_load(636, 200); step(); tick();
    check("t3_wrap_r", 32'(x0), 32'd2);
    speed = 4'd5; dir = 1'b1;
    do_load(3, 200); step(); tick();
    check("t3_wrap_l", 32'(x0), 32'd638);

    // 4: collision halts, freezes, then clears
    dir = 1'b0; speed = 4'd4;
    do_load(100, 200); step();
    px = 11'd120; py = 11'd210;
    tick();
    check("t4_hit", 32'(hit), 32'd1);
    check("t4_halt", 32'(moving), 32'd0);
    check("t4_x", 32'(x0), 32'd100);
    tick();
    check("t4_frozen", 32'(x0), 32'd100);
    clr_hit = 1'b1; step(); clr_hit = 1'b0;
    check("t4_clr", 32'(hit), 32'd0);
    check("t4_rerun", 32'(moving), 32'd1);

    // 5: overlap boundary at exactly SPRITE_W
    px = 11'd1500; speed = 4'd0;
    do_load(200, 300); step();
    px = 11'd232; py = 11'd300;
    tick(); check("t5_edge32", 32'(hit), 32'd0);
    px = 11'd231;
    tick(); check("t5_edge31", 32'(hit), 32'd1);

    // 6: reset while halted, then load coinciding with a tick
    reset = 1'b1; step(); reset = 1'b0;
    check("t6_rst_hit", 32'(hit), 32'd0);
    check("t6_rst_x", 32'(x0), 32'd0);
    px = 11'd1500; py = 11'd1500; speed = 4'd4;
    do_load(50, 100); step(); tick();
    frame_tick = 1'b1; load = 1'b1; x_init = 11'd300;
    step();
    frame_tick = 1'b0; load = 1'b0;
    check("t6_load_x", 32'(x0), 32'd300);
    check("t6_load_idle", 32'(moving), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      load       = ($urandom_range(0, 39) == 0);
      x_init     = 11'($urandom_range(0, HR - 1));
      y_lane     = 11'($urandom_range(0, 479));
      frame_tick = ($urandom_range(0, 2) == 0);
      en         = ($urandom_range(0, 15) != 0);
      clr_hit    = ($urandom_range(0, 5) == 0);
      dir        = ($urandom_range(0, 7) == 0) ? ~dir : dir;
      speed      = 4'($urandom);
      if ($urandom_range(0, 30) == 0) frame_div = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        px = 11'((m_x + $urandom_range(0, 80) + 2048 - 40) % 2048);
        py = 11'((m_y + $urandom_range(0, 80) + 2048 - 40) % 2048);
      end else begin
        px = 11'($urandom_range(0, HR - 1));
        py = 11'($urandom_range(0, 479));
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
